uart_rx_ctrl: RTL and testbench

Receive-side control FSM of the UART. It synchronizes the serial `rx` line, detects and qualifies the start bit with 16x oversampling, and samples each data bit and the stop bit at mid-bit. Each sample is issued as a one-cycle `shift_en`/`shift_d` pulse to the 9-bit LSB-first receive shift register, whose `q[7:0]` carries the data byte and `q[8]` the stop bit. The block also reports frame completion, framing errors and overrun to the host-side logic through a valid/ack flag.

---
 rtl/uart_rx_ctrl_pkg.sv | 16 +
 rtl/uart_rx_ctrl_sync_2ff.sv | 20 ++
 rtl/uart_rx_ctrl.sv | 137 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART receive definitions: FSM state encoding and frame geometry defaults.
package uart_rx_ctrl_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;
    // Data bits plus the stop bit; also the width of the receive shift register.
    localparam int FRAME_BITS     = DATA_BITS_DEF + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] ff_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ff_q <= {2{RST_VAL}};
        else       ff_q <= {ff_q[0], d};
    end

    assign q = ff_q[1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: start-bit qualification, mid-bit sampling into an external
// LSB-first shift register, and host-side valid/ack, framing-error and overrun flags.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic baud_tick,
    input  logic rx,
    input  logic rx_ack,
    output logic shift_en,
    output logic shift_d,
    output logic busy,
    output logic rx_done,
    output logic rx_valid,
    output logic frame_err,
    output logic overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bitn_q, bitn_d;
    logic          armed_q, armed_d;
    logic          stop_bit_q, stop_bit_d;
    logic          done_q, done_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
    logic          rx_s;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bitn_q     <= '0;
            armed_q    <= 1'b1;
            stop_bit_q <= 1'b1;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitn_q     <= bitn_d;
            armed_q    <= armed_d;
            stop_bit_q <= stop_bit_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitn_d     = bitn_q;
        armed_d    = armed_q;
        stop_bit_d = stop_bit_q;
        done_d     = 1'b0;
        shift_en   = 1'b0;
        shift_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // Re-arm only after the line has been seen high again.
                if (rx_s) armed_d = 1'b1;
                if (baud_tick && !rx_s && armed_q) state_d = ST_START;
            end
            ST_START: begin
                if (baud_tick) begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_d  = '0;
                        bitn_d = '0;
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (cnt_q == LAST_CNT) begin
                        shift_en = 1'b1;
                        shift_d  = rx_s;
                        cnt_d    = '0;
                        bitn_d   = bitn_q + 1'b1;
                        if (bitn_q == LAST_BIT) state_d = ST_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (cnt_q == LAST_CNT) begin
                        shift_en   = 1'b1;
                        shift_d    = rx_s;
                        stop_bit_d = rx_s;
                        done_d     = 1'b1;
                        cnt_d      = '0;
                        if (!rx_s) armed_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A completing frame takes priority over a same-cycle acknowledge.
    assign valid_d = done_q | (valid_q & ~rx_ack);
    assign ovr_d   = ovr_q | (done_q & valid_q & ~rx_ack);

    assign busy      = (state_q != ST_IDLE);
    assign rx_done   = done_q;
    assign rx_valid  = valid_q;
    assign frame_err = ~stop_bit_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: baud_tick every 4 clk, 16x oversampling, 64 clk per bit.
module tb_uart_rx_ctrl;
    import uart_rx_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic baud_tick = 1'b0;
    logic rx = 1'b1;
    logic rx_ack = 1'b0;
    logic shift_en, shift_d, busy, rx_done, rx_valid, frame_err, overrun;

    uart_rx_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .baud_tick (baud_tick),
        .rx        (rx),
        .rx_ack    (rx_ack),
        .shift_en  (shift_en),
        .shift_d   (shift_d),
        .busy      (busy),
        .rx_done   (rx_done),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int   div = 0;
    logic ack_req = 1'b0;
    logic ack_on_done = 1'b0;

    always @(posedge clk) begin
        #1;
        baud_tick = (div == 3);
        div = (div + 1) % 4;
        rx_ack = ack_req | (ack_on_done & rx_done);
    end

    // Receive shift register model plus event counters, sampled mid-cycle.
    logic [FRAME_BITS-1:0] shreg = '0, last_q = '0, prev_q = '0;
    int   n_shift = 0, n_done = 0, busy_cycles = 0;
    logic last_ferr = 1'b0, prev_ferr = 1'b0, prev_done = 1'b0;
    logic ovr_after = 1'b0, valid_after = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            shreg = '0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) begin
                ovr_after = overrun;
                valid_after = rx_valid;
            end
            if (shift_en) begin
                shreg = {shift_d, shreg[FRAME_BITS-1:1]};
                n_shift++;
            end
            if (rx_done) begin
                n_done++;
                prev_q = last_q;
                last_q = shreg;
                prev_ferr = last_ferr;
                last_ferr = frame_err;
            end
            if (busy) busy_cycles++;
            prev_done = rx_done;
        end
    end

    int compared = 0, mismatched = 0;

    task automatic drive_bit(input logic b);
        @(posedge clk); #1; rx = b;
        repeat (63) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1; rx = 1'b1;
        repeat (n - 1) @(posedge clk);
        #1;
    endtask

    task automatic do_ack();
        @(posedge clk); #2; ack_req = 1'b1;
        @(posedge clk); #2; ack_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #3; reset = 1'b1;
        repeat (3) @(posedge clk);
        #3; reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (4) @(posedge clk);
        #3;
        compared++;
        if ({shift_en, busy, rx_done, rx_valid} !== 4'b0) begin
            mismatched++; $display("FAIL reset_ctrl_outs: got %b want 0000", {shift_en, busy, rx_done, rx_valid});
        end
        compared++;
        if ({frame_err, overrun} !== 2'b0) begin
            mismatched++; $display("FAIL reset_flags: got %b want 00", {frame_err, overrun});
        end
        reset = 1'b0;
        idle(16);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++; $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_normal();
        int s, d;
        s = n_shift; d = n_done;
        send_frame(8'hA5, 1'b1);
        idle(32);
        compared++;
        if (n_shift - s !== 9) begin
            mismatched++; $display("FAIL normal_shift_count: got %0d want 9", n_shift - s);
        end
        compared++;
        if (last_q !== 9'h1A5) begin
            mismatched++; $display("FAIL normal_q: got %h want 1a5", last_q);
        end
        compared++;
        if (n_done - d !== 1) begin
            mismatched++; $display("FAIL normal_done_count: got %0d want 1", n_done - d);
        end
        compared++;
        if (rx_valid !== 1'b1 || last_ferr !== 1'b0) begin
            mismatched++; $display("FAIL normal_valid_ferr: got %b%b want 10", rx_valid, last_ferr);
        end
        do_ack();
        compared++;
        if (rx_valid !== 1'b0) begin
            mismatched++; $display("FAIL normal_ack_clear: got %b want 0", rx_valid);
        end
    endtask

    task automatic test_false_start();
        int s, d, b;
        s = n_shift; d = n_done; b = busy_cycles;
        @(posedge clk); #1; rx = 1'b0;
        repeat (16) @(posedge clk);
        #1; rx = 1'b1;
        repeat (28) @(posedge clk);
        #1;
        compared++;
        if (busy_cycles == b) begin
            mismatched++; $display("FAIL false_start_entered: got busy_cycles %0d want >0", busy_cycles - b);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++; $display("FAIL false_start_idle_by_tick8: got busy %b want 0", busy);
        end
        idle(64);
        compared++;
        if (n_shift !== s || n_done !== d) begin
            mismatched++; $display("FAIL false_start_no_shift: got shifts %0d dones %0d want 0 0", n_shift - s, n_done - d);
        end
    endtask

    task automatic test_framing();
        int d, s2, d2, b;
        d = n_done;
        send_frame(8'h3C, 1'b0);
        compared++;
        if (n_done - d !== 1 || last_ferr !== 1'b1) begin
            mismatched++; $display("FAIL framing_err_flag: got dones %0d ferr %b want 1 1", n_done - d, last_ferr);
        end
        compared++;
        if (last_q !== 9'h03C) begin
            mismatched++; $display("FAIL framing_q: got %h want 03c", last_q);
        end
        s2 = n_shift; d2 = n_done; b = busy_cycles;
        repeat (3 * 64) @(posedge clk);
        #1;
        compared++;
        if (n_shift !== s2 || busy_cycles !== b || n_done !== d2) begin
            mismatched++; $display("FAIL framing_no_restart: got shifts %0d busy %0d want 0 0", n_shift - s2, busy_cycles - b);
        end
        idle(64);
        do_ack();
        send_frame(8'h55, 1'b1);
        idle(32);
        compared++;
        if (last_q !== 9'h155 || n_done - d2 !== 1) begin
            mismatched++; $display("FAIL framing_recover_q: got %h dones %0d want 155 1", last_q, n_done - d2);
        end
        compared++;
        if (last_ferr !== 1'b0 || frame_err !== 1'b0) begin
            mismatched++; $display("FAIL framing_recover_ferr: got %b want 0", last_ferr);
        end
    endtask

    task automatic test_overrun();
        int d;
        do_reset();
        idle(16);
        d = n_done;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(32);
        compared++;
        if (n_done - d !== 2 || last_q !== 9'h122 || prev_q !== 9'h111) begin
            mismatched++; $display("FAIL overrun_frames: got dones %0d q %h/%h want 2 111/122", n_done - d, prev_q, last_q);
        end
        compared++;
        if (ovr_after !== 1'b1 || valid_after !== 1'b1) begin
            mismatched++; $display("FAIL overrun_set: got ovr %b valid %b want 1 1", ovr_after, valid_after);
        end
        do_reset();
        idle(16);
        compared++;
        if (overrun !== 1'b0) begin
            mismatched++; $display("FAIL overrun_reset_clear: got %b want 0", overrun);
        end
        send_frame(8'h11, 1'b1);
        ack_on_done = 1'b1;
        send_frame(8'h22, 1'b1);
        idle(32);
        ack_on_done = 1'b0;
        compared++;
        if (valid_after !== 1'b1 || rx_valid !== 1'b1) begin
            mismatched++; $display("FAIL overrun_ack_same_cycle_valid: got %b want 1", valid_after);
        end
        compared++;
        if (overrun !== 1'b0) begin
            mismatched++; $display("FAIL overrun_ack_same_cycle_ovr: got %b want 0", overrun);
        end
    endtask

    task automatic test_reset_mid();
        int d;
        logic [7:0] v;
        v = 8'h5A;
        d = n_done;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(v[i]);
        #2;
        compared++;
        if (busy !== 1'b1) begin
            mismatched++; $display("FAIL reset_mid_busy_before: got %b want 1", busy);
        end
        reset = 1'b1;
        #1;
        compared++;
        if ({shift_en, busy, rx_done, rx_valid, frame_err, overrun} !== 6'b0) begin
            mismatched++; $display("FAIL reset_mid_outputs: got %b want 000000",
                                   {shift_en, busy, rx_done, rx_valid, frame_err, overrun});
        end
        repeat (3) @(posedge clk);
        #3; reset = 1'b0;
        idle(6 * 64);
        compared++;
        if (n_done !== d) begin
            mismatched++; $display("FAIL reset_mid_no_done: got %0d want 0", n_done - d);
        end
        send_frame(8'hF0, 1'b1);
        idle(32);
        compared++;
        if (last_q !== 9'h1F0 || n_done - d !== 1 || last_ferr !== 1'b0) begin
            mismatched++; $display("FAIL reset_mid_next_frame: got %h dones %0d ferr %b want 1f0 1 0", last_q, n_done - d, last_ferr);
        end
    endtask

    task automatic test_back_to_back();
        int s, d;
        do_ack();
        s = n_shift; d = n_done;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(32);
        compared++;
        if (n_shift - s !== 18 || n_done - d !== 2) begin
            mismatched++; $display("FAIL b2b_counts: got shifts %0d dones %0d want 18 2", n_shift - s, n_done - d);
        end
        compared++;
        if (prev_q !== 9'h100 || last_q !== 9'h1FF) begin
            mismatched++; $display("FAIL b2b_data: got %h/%h want 100/1ff", prev_q, last_q);
        end
        compared++;
        if (prev_ferr !== 1'b0 || last_ferr !== 1'b0) begin
            mismatched++; $display("FAIL b2b_ferr: got %b%b want 00", prev_ferr, last_ferr);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_false_start();
        test_framing();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
